// File: rtl/branch_pkg.sv
// Shared encodings for the branch unit: branch condition classes and FSM states.
package branch_pkg;

  typedef enum logic [2:0] {
    COND_RET  = 3'b000,
    COND_JNZ  = 3'b001,
    COND_JNC  = 3'b010,
    COND_CALL = 3'b011,
    COND_JMP  = 3'b100,
    COND_JZ   = 3'b101,
    COND_JC   = 3'b110,
    COND_JN   = 3'b111
  } cond_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/branch_unit_ret_stack.sv
// LIFO return-address stack; push on a full stack and pop on an empty stack are ignored.
module ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] top_o
);

  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [IW-1:0] wr_idx, rd_idx;
  logic          do_push, do_pop;

  assign full_o  = (ptr_q == PW'(DEPTH));
  assign empty_o = (ptr_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign wr_idx  = IW'(ptr_q);
  assign rd_idx  = IW'(ptr_q - PW'(1));
  assign top_o   = mem_q[rd_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (do_push) begin
      ptr_d = ptr_q + PW'(1);
    end else if (do_pop) begin
      ptr_d = ptr_q - PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Entries need no reset: an entry is only read after it has been pushed.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: evaluates conditions, drives a one-cycle redirect pulse,
// holds a flush window afterwards and manages the CALL/RET return stack.
module branch_unit
  import branch_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned STACK_DEPTH  = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ctrl_jmp_i,
  input  logic [2:0]        cond_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic [ADDR_W-1:0] pc_next_i,
  input  logic              flag_we_i,
  input  logic              flag_z_i,
  input  logic              flag_c_i,
  input  logic              flag_n_i,
  output logic              branch_o,
  output logic [ADDR_W-1:0] target_o,
  output logic              flush_o,
  output logic              busy_o,
  output logic [2:0]        flags_o,
  output logic              stack_err_o
);

  localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        flags_q, flags_d;
  logic              branch_q, branch_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              err_q, err_d;

  cond_e             cond;
  logic [2:0]        flags_eff;
  logic              taken;
  logic              push, pop, full, empty;
  logic [ADDR_W-1:0] top;

  assign cond      = cond_e'(cond_i);
  // Same-cycle flag writes bypass the register for condition evaluation ({N,C,Z}).
  assign flags_eff = flag_we_i ? {flag_n_i, flag_c_i, flag_z_i} : flags_q;

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_RET:  taken = !empty;
      COND_JNZ:  taken = !flags_eff[0];
      COND_JNC:  taken = !flags_eff[1];
      COND_CALL: taken = 1'b1;
      COND_JMP:  taken = 1'b1;
      COND_JZ:   taken = flags_eff[0];
      COND_JC:   taken = flags_eff[1];
      COND_JN:   taken = flags_eff[2];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    branch_d = 1'b0;
    target_d = target_q;
    err_d    = err_q;
    push     = 1'b0;
    pop      = 1'b0;
    flags_d  = flag_we_i ? {flag_n_i, flag_c_i, flag_z_i} : flags_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_jmp_i) begin
          if (cond == COND_CALL) begin
            if (full) err_d = 1'b1;
            else      push  = 1'b1;
          end
          if (cond == COND_RET) begin
            if (empty) err_d = 1'b1;
            else       pop   = 1'b1;
          end
          if (taken) begin
            branch_d = 1'b1;
            target_d = (cond == COND_RET) ? top : target_i;
            state_d  = ST_FLUSH;
            cnt_d    = '0;
          end
        end
      end
      ST_FLUSH: begin
        if (cnt_q == CW'(FLUSH_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      flags_q  <= '0;
      branch_q <= 1'b0;
      target_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flags_q  <= flags_d;
      branch_q <= branch_d;
      target_q <= target_d;
      err_q    <= err_d;
    end
  end

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_ret_stack (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_next_i),
    .full_o  (full),
    .empty_o (empty),
    .top_o   (top)
  );

  assign branch_o    = branch_q;
  assign target_o    = target_q;
  assign flush_o     = (state_q == ST_FLUSH);
  assign busy_o      = (state_q == ST_FLUSH);
  assign flags_o     = flags_q;
  assign stack_err_o = err_q;

endmodule
